// File: rtl/rv_m_pkg.sv
// Shared definitions for the M-extension execute unit: funct3 encodings,
// FSM state type and small decode helpers.
package rv_m_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Divide ops with funct3[0] clear (DIV/REM) work on signed operands.
  function automatic logic is_signed_div(input logic [2:0] f3);
    return f3[2] & ~f3[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider datapath: one shift/compare/subtract per step on
// unsigned operands. Outputs are the quotient/remainder after the current step.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN-1:0] rem_d, quo_d;
  logic [XLEN:0]   shifted, diff;
  logic            ge;

  // The partial remainder stays below the divisor, so XLEN+1 bits hold the shift.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = ~diff[XLEN];
    rem_d   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign quot_o = quo_d;
  assign rem_o  = rem_d;

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage M-extension unit: 2-cycle registered multiply, 32-step restoring
// divide, RISC-V special-case results, pipeline hold via busyE.
module muldiv_unit
  import rv_m_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_STEPS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            startE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] srcAE,
  input  logic [XLEN-1:0] srcBE,
  input  logic            flushE,
  output logic            busyE,
  output logic            doneE,
  output logic [XLEN-1:0] resultE
);

  localparam int CNT_W = $clog2(DIV_STEPS);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f3_q;
  logic [XLEN-1:0]  a_q, b_q, res_q;
  logic             negq_q, negr_q;

  logic             start_ok, sgn_in, div_spec, ext_a, ext_b;
  logic [XLEN-1:0]  spec_res, dvd, dvs, quot, rem, div_res, mul_res;
  logic signed [2*XLEN-1:0] mul_a, mul_b, prod;

  always_comb begin
    start_ok = (state_q == IDLE) && startE && !flushE;
    sgn_in   = is_signed_div(funct3E);
    div_spec = is_div(funct3E) &&
               ((srcBE == '0) || (sgn_in && srcAE == MIN_NEG && srcBE == '1));
    if (srcBE == '0) spec_res = funct3E[1] ? srcAE : '1;
    else             spec_res = funct3E[1] ? '0 : srcAE;
    dvd = (sgn_in && srcAE[XLEN-1]) ? -srcAE : srcAE;
    dvs = (sgn_in && srcBE[XLEN-1]) ? -srcBE : srcBE;
  end

  // Sign-extending to 2*XLEN gives the exact 33x33 product in the low 64 bits.
  always_comb begin
    ext_a   = (f3_q[1:0] != 2'b11);
    ext_b   = ~f3_q[1];
    mul_a   = {{XLEN{ext_a & a_q[XLEN-1]}}, a_q};
    mul_b   = {{XLEN{ext_b & b_q[XLEN-1]}}, b_q};
    prod    = mul_a * mul_b;
    mul_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    div_res = f3_q[1] ? (negr_q ? -rem : rem) : (negq_q ? -quot : quot);
  end

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk       (clk),
    .load_i    (start_ok),
    .step_i    (state_q == DIV),
    .dividend_i(dvd),
    .divisor_i (dvs),
    .quot_o    (quot),
    .rem_o     (rem)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) begin
        if (!is_div(funct3E)) state_d = MUL;
        else if (div_spec)    state_d = DONE;
        else                  state_d = DIV;
      end
      MUL:  state_d = flushE ? IDLE : DONE;
      DIV:  if (flushE) state_d = IDLE;
            else if (cnt_q == '0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busyE = start_ok || (((state_q == MUL) || (state_q == DIV)) && !flushE);
    doneE = (state_q == DONE) && !flushE;
  end

  always_ff @(posedge clk) begin
    if (start_ok) begin
      f3_q   <= funct3E;
      a_q    <= srcAE;
      b_q    <= srcBE;
      negq_q <= sgn_in && (srcAE[XLEN-1] ^ srcBE[XLEN-1]);
      negr_q <= sgn_in && srcAE[XLEN-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      if (start_ok)
        cnt_q <= CNT_W'(DIV_STEPS - 1);
      else if (state_q == DIV && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;

      if (start_ok && div_spec)
        res_q <= spec_res;
      else if (state_q == MUL && !flushE)
        res_q <= mul_res;
      else if (state_q == DIV && cnt_q == '0 && !flushE)
        res_q <= div_res;
    end
  end

  assign resultE = res_q;

endmodule
